// File: rtl/shblk_sbox_sequencer.sv
// Purpose : feeds one shared pipelined masked S-box byte by byte from a block-based masked state.
// Latency : accept in cycle T, out_valid in cycle T+NBYTES+SBOX_LAT+1; one state in flight at a time.
// Backpr. : in_ready only in IDLE; S-box issue never stalls; out_ready is only sampled in DONE.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake; in_state is block-based (share j at [8*NBYTES*j +: 8*NBYTES])
//   sb_in/sb_in_valid bit-based byte to the S-box (bit b of share j at index d*b+j), zero when idle
//   sb_out            bit-based S-box result, SBOX_LAT cycles after the matching sb_in
//   out_valid/out_ready/out_state  result handshake, block-based like in_state
//   busy              high whenever the FSM is not IDLE
//
// Build option: define SHBLK_SEQ_CLEAR_EN to zero the captured input and the result on DONE->IDLE.

module shblk_sbox_sequencer #(
  parameter int d        = 2,
  parameter int NBYTES   = 16,
  parameter int SBOX_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [d*8*NBYTES-1:0]   in_state,
  output logic [d*8-1:0]          sb_in,
  output logic                    sb_in_valid,
  input  logic [d*8-1:0]          sb_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [d*8*NBYTES-1:0]   out_state,
  output logic                    busy
);

  localparam int SW = 8 * NBYTES;             // bits per share
  localparam int TW = d * SW;                 // bits per full state
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } st_t;

  st_t st, st_nxt;

  logic [TW-1:0]       state_q;   // captured input state
  logic [TW-1:0]       res_q;     // substituted state, filled one byte per capture
  logic [CW-1:0]       icnt;      // next byte to issue
  logic [CW-1:0]       ccnt;      // next byte to capture
  logic [SBOX_LAT-1:0] vsr;       // one bit per S-box pipeline stage, set for live bytes

  logic                cap;       // sb_out carries a live byte this cycle
  logic [7:0]          ibyte;
  logic [7:0]          cbyte;
  logic [TW-1:0]       cap_ins;
  logic [TW-1:0]       cap_mask;

  // The top stage of vsr lines up with the byte the S-box is presenting now.
  // Gating with the FSM state keeps anything from being captured in IDLE/DONE.
  assign cap = vsr[SBOX_LAT-1] && ((st == ISSUE) || (st == DRAIN));

  assign out_state = res_q;

  // ------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM next state and control outputs
  // ------------------------------------------------------------------
  always_comb begin
    st_nxt      = st;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    sb_in_valid = 1'b0;
    busy        = 1'b1;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          st_nxt = ISSUE;
        end
      end
      ISSUE: begin
        sb_in_valid = 1'b1;
        // The last byte can never be captured while still issuing, since
        // capture trails issue by at least one cycle; only DRAIN ends capture.
        if (icnt == LAST) begin
          st_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cap && (ccnt == LAST)) begin
          st_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          st_nxt = IDLE;
        end
      end
      default: begin
        st_nxt = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Block-to-bit conversion of the byte being issued. Byte selection uses
  // shifts so the variable counter never appears as a part-select index.
  // Outside ISSUE the bus is forced to zero so no share bits leak.
  // ------------------------------------------------------------------
  always_comb begin
    sb_in = '0;
    ibyte = '0;
    if (st == ISSUE) begin
      for (int j = 0; j < d; j++) begin
        ibyte = 8'(state_q >> (SW * j + 8 * int'(icnt)));
        for (int b = 0; b < 8; b++) begin
          sb_in[d*b+j] = ibyte[b];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Bit-to-block conversion of the returning byte into result slot ccnt,
  // expressed as an insert value plus a keep-mask over the whole state.
  // ------------------------------------------------------------------
  always_comb begin
    cap_ins  = '0;
    cap_mask = '0;
    cbyte    = '0;
    for (int j = 0; j < d; j++) begin
      for (int b = 0; b < 8; b++) begin
        cbyte[b] = sb_out[d*b+j];
      end
      cap_ins  = cap_ins  | (TW'(cbyte) << (SW * j + 8 * int'(ccnt)));
      cap_mask = cap_mask | (TW'(8'hFF) << (SW * j + 8 * int'(ccnt)));
    end
  end

  // ------------------------------------------------------------------
  // Datapath: state capture, counters, in-flight tracking, result capture
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      res_q   <= '0;
      icnt    <= '0;
      ccnt    <= '0;
      vsr     <= '0;
    end else begin
      // In-flight tracking follows the S-box pipeline one stage per cycle.
      vsr[0] <= sb_in_valid;
      for (int k = 1; k < SBOX_LAT; k++) begin
        vsr[k] <= vsr[k-1];
      end

      case (st)
        IDLE: begin
          if (in_valid) begin
            state_q <= in_state;
            icnt    <= '0;
            ccnt    <= '0;
          end
        end
        ISSUE: begin
          // Hold at the last index instead of wrapping.
          if (icnt != LAST) begin
            icnt <= icnt + 1'b1;
          end
        end
        DONE: begin
`ifdef SHBLK_SEQ_CLEAR_EN
          if (out_ready) begin
            state_q <= '0;
            res_q   <= '0;
          end
`endif
        end
        default: begin
        end
      endcase

      if (cap) begin
        res_q <= (res_q & ~cap_mask) | cap_ins;
        if (ccnt != LAST) begin
          ccnt <= ccnt + 1'b1;
        end
      end
    end
  end

endmodule
